// File: rtl/floor_req_queue_if.sv
// Request/response bundle between the call-button encoder, the floor queue and the
// motion controller. clk and rst stay as plain ports on the queue.
interface floor_req_queue_if #(
    parameter int unsigned pFLOOR_WIDTH = 4,
    parameter int unsigned pPTR_WIDTH   = 4
);
    logic [pFLOOR_WIDTH-1:0] i_wr_data;
    logic                    i_wr_en;
    logic                    i_rd_en;
    logic                    i_clr_err;
    logic [pFLOOR_WIDTH-1:0] o_rd_data;
    logic                    o_rd_valid;
    logic [pPTR_WIDTH:0]     o_count;
    logic                    o_empty;
    logic                    o_full;
    logic                    o_almost_full;
    logic                    o_dup_drop;
    logic                    o_overflow;
    logic                    o_underflow;

    modport master (
        output i_wr_data, i_wr_en, i_rd_en, i_clr_err,
        input  o_rd_data, o_rd_valid, o_count, o_empty, o_full, o_almost_full,
               o_dup_drop, o_overflow, o_underflow
    );

    modport slave (
        input  i_wr_data, i_wr_en, i_rd_en, i_clr_err,
        output o_rd_data, o_rd_valid, o_count, o_empty, o_full, o_almost_full,
               o_dup_drop, o_overflow, o_underflow
    );
endinterface

// File: rtl/floor_req_queue.sv
// Floor-request FIFO with full-depth occupancy, registered read port, occupancy
// status, sticky overflow/underflow flags and optional duplicate-floor suppression.
module floor_req_queue #(
    parameter int unsigned pFLOOR_WIDTH = 4,
    parameter int unsigned pDEPTH       = 16,
    parameter int unsigned pPTR_WIDTH   = 4,
    parameter int unsigned pALMOST_FULL = 14,
    parameter int unsigned pDEDUP       = 1
) (
    input  logic             i_clock,
    input  logic             i_rst,
    floor_req_queue_if.slave bus
);
    localparam int unsigned CntW = pPTR_WIDTH + 1;
    localparam logic [CntW-1:0] CntFull  = CntW'(pDEPTH);
    localparam logic [CntW-1:0] CntAfull = CntW'(pALMOST_FULL);

    logic [pFLOOR_WIDTH-1:0] mem [pDEPTH];

    logic [pPTR_WIDTH-1:0]   wr_ptr_q, wr_ptr_d;
    logic [pPTR_WIDTH-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]         count_q, count_d;
    logic [pFLOOR_WIDTH-1:0] rd_data_q, rd_data_d;
    logic                    rd_valid_q, rd_valid_d;
    logic                    dup_drop_q, dup_drop_d;
    logic                    overflow_q, overflow_d;
    logic                    underflow_q, underflow_d;

    logic                    is_dup;
    logic                    rd_acc;
    logic                    wr_acc;
    logic [pPTR_WIDTH-1:0]   ofs;

    // An entry is occupied when its distance from the read pointer is below the count,
    // so the head being read this cycle still counts as a duplicate target.
    always_comb begin
        is_dup = 1'b0;
        ofs    = '0;
        if (pDEDUP != 0) begin
            for (int unsigned i = 0; i < pDEPTH; i++) begin
                ofs = i[pPTR_WIDTH-1:0] - rd_ptr_q;
                if (({1'b0, ofs} < count_q) && (mem[i[pPTR_WIDTH-1:0]] == bus.i_wr_data)) begin
                    is_dup = 1'b1;
                end
            end
        end
    end

    always_comb begin
        rd_acc      = bus.i_rd_en && (count_q != '0);
        wr_acc      = bus.i_wr_en && !is_dup && ((count_q != CntFull) || rd_acc);
        wr_ptr_d    = wr_acc ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d    = rd_acc ? rd_ptr_q + 1'b1 : rd_ptr_q;
        rd_data_d   = rd_acc ? mem[rd_ptr_q] : rd_data_q;
        rd_valid_d  = rd_acc;
        dup_drop_d  = bus.i_wr_en && is_dup;
        count_d     = count_q;
        unique case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        // A set in the same cycle as a clear wins.
        overflow_d  = (bus.i_wr_en && !is_dup && (count_q == CntFull) && !rd_acc) ||
                      (overflow_q && !bus.i_clr_err);
        underflow_d = (bus.i_rd_en && (count_q == '0)) || (underflow_q && !bus.i_clr_err);
    end

    always_ff @(posedge i_clock or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            rd_data_q   <= '0;
            rd_valid_q  <= 1'b0;
            dup_drop_q  <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            rd_data_q   <= rd_data_d;
            rd_valid_q  <= rd_valid_d;
            dup_drop_q  <= dup_drop_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    always_ff @(posedge i_clock) begin
        if (wr_acc) begin
            mem[wr_ptr_q] <= bus.i_wr_data;
        end
    end

    assign bus.o_rd_data     = rd_data_q;
    assign bus.o_rd_valid    = rd_valid_q;
    assign bus.o_count       = count_q;
    assign bus.o_empty       = (count_q == '0);
    assign bus.o_full        = (count_q == CntFull);
    assign bus.o_almost_full = (count_q >= CntAfull);
    assign bus.o_dup_drop    = dup_drop_q;
    assign bus.o_overflow    = overflow_q;
    assign bus.o_underflow   = underflow_q;
endmodule
